// File: rtl/pattern_seq_gen_pkg.sv
// pattern_seq_gen_pkg: shared mode/state enums and the alternating-word helper
package pattern_seq_gen_pkg;
  localparam int PAT_MAX_W = 4096;
  typedef enum logic [1:0] {PAT_ALT, PAT_WALK, PAT_COUNT, PAT_LFSR} pat_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} pat_state_e;
  function automatic logic [PAT_MAX_W-1:0] alt_word(input int width, input logic pol);
    alt_word = '0;
    for (int i = 0; i < width; i++) alt_word[i] = pol ^ i[0];
  endfunction
endpackage

// File: rtl/pattern_seq_gen_lfsr.sv
// pattern_lfsr: Fibonacci LFSR, shift left with XOR of tapped bits into LSB
module pattern_lfsr #(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TAPS = WIDTH'('h60)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_state
);
  logic [WIDTH-1:0] r_state;
  always_ff @(posedge clk) begin
    if (!rst_n || i_load) r_state <= SEED;
    else if (i_advance) r_state <= {r_state[WIDTH-2:0], ^(r_state & TAPS)};
  end
  assign o_state = r_state;
endmodule

// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: valid/ready pattern stream generator; LFSR mode under PATTERN_SEQ_GEN_LFSR_EN
module pattern_seq_gen
  import pattern_seq_gen_pkg::*;
#(
  parameter int WIDTH = 127,
  parameter int CNT_W = 16,
  parameter logic [WIDTH-1:0] LFSR_SEED = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'('h60)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             polarity,
  input  logic [CNT_W-1:0] beats,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam logic [PAT_MAX_W-1:0] ALT_FULL = alt_word(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0] ALT_INIT = ALT_FULL[WIDTH-1:0];
  pat_state_e       r_state, w_state_nxt;
  pat_mode_e        r_mode, w_mode_in;
  logic             r_pol;
  logic [CNT_W-1:0] r_beats, r_cnt;
  logic [WIDTH-1:0] r_pat, w_pat_init, w_pat_adv, w_word;
  logic             w_load, w_accept, w_last;
  assign w_load   = (r_state == ST_IDLE) && start && (beats != '0);
  assign w_accept = (r_state == ST_RUN) && out_ready;
  assign w_last   = r_cnt == r_beats - 1'b1;
`ifdef PATTERN_SEQ_GEN_LFSR_EN
  logic [WIDTH-1:0] w_lfsr;
  assign w_mode_in = pat_mode_e'(mode);
  pattern_lfsr #(.WIDTH(WIDTH), .SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load && w_mode_in == PAT_LFSR),
    .i_advance(w_accept && r_mode == PAT_LFSR),
    .o_state  (w_lfsr)
  );
  assign w_word = (r_mode == PAT_LFSR) ? w_lfsr : r_pat;
`else
  assign w_mode_in = (mode == PAT_LFSR) ? PAT_ALT : pat_mode_e'(mode);
  assign w_word    = r_pat;
`endif
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (beats != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (stop) w_state_nxt = ST_IDLE;
               else if (w_accept && w_last) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    w_pat_init = (w_mode_in == PAT_WALK)  ? {{(WIDTH-1){1'b0}}, 1'b1} :
                 (w_mode_in == PAT_COUNT) ? '0 : ALT_INIT;
    w_pat_adv  = (r_mode == PAT_WALK)  ? {r_pat[WIDTH-2:0], r_pat[WIDTH-1]} :
                 (r_mode == PAT_COUNT) ? r_pat + 1'b1 : ~r_pat;
  end
  // Internal pattern is kept in positive polarity; polarity is applied on output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= PAT_ALT;
      r_pol   <= 1'b1;
      r_beats <= '0;
      r_cnt   <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_mode  <= w_mode_in;
        r_pol   <= polarity;
        r_beats <= beats;
        r_cnt   <= '0;
        r_pat   <= w_pat_init;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        r_pat <= w_pat_adv;
      end
    end
  end
  assign data_out  = r_pol ? w_word : ~w_word;
  assign out_valid = r_state == ST_RUN;
  assign busy      = r_state == ST_RUN;
  assign done      = r_state == ST_DONE;
endmodule

// File: tb/tb_pattern_seq_gen.sv
// tb_pattern_seq_gen: scoreboard bench for pattern_seq_gen
module tb_pattern_seq_gen;
`ifdef PATTERN_SEQ_GEN_LFSR_EN
  localparam int W = 7;
`else
  localparam int W = 8;
`endif
  localparam logic [W-1:0] TAPS = W'('h60);
  logic clk = 1'b0;
  logic rst_n, start, stop, polarity, out_ready, out_valid, busy, done;
  logic [1:0] mode;
  logic [15:0] beats;
  logic [W-1:0] data_out;
  logic [W-1:0] exp_q[$];
  int n_cmp = 0, n_err = 0, n_done = 0, cyc = 0, d0 = 0;
  logic stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  pattern_seq_gen #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .polarity(polarity), .beats(beats), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [1:0] m, input logic p, input int k);
    logic [W-1:0] w, s;
    int mm;
    mm = int'(m);
`ifndef PATTERN_SEQ_GEN_LFSR_EN
    if (mm == 3) mm = 0;
`endif
    w = '0;
    case (mm)
      0: for (int i = 0; i < W; i++) w[i] = ((i + k) % 2) == 0;
      1: w[k % W] = 1'b1;
      2: w = k[W-1:0];
      default: begin
        s = '1;
        for (int j = 0; j < k; j++) s = {s[W-2:0], ^(s & TAPS)};
        w = s;
      end
    endcase
    return p ? w : ~w;
  endfunction

  always @(negedge clk) begin
    if (stall_prev && out_valid) chk("hold", data_out, prev_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 1, 0);
      else chk("word", data_out, exp_q.pop_front());
    end
    stall_prev = out_valid && !out_ready;
    prev_data = data_out;
    if (done) n_done++;
  end

  task automatic go(input logic [1:0] m, input logic p, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word(m, p, k));
    mode = m; polarity = p; beats = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int c);
    logic found;
    found = 1'b0; c = 0;
    while (!found && c < max) begin
      @(negedge clk);
      c++;
      if (done) found = 1'b1;
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; polarity = 1'b1;
    out_ready = 1'b1; mode = 2'd0; beats = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // ALT pol=1, 3 beats back to back
    d0 = n_done;
    go(2'd0, 1'b1, 3);
    chk("t1_valid", out_valid, 1);
    chk("t1_busy", busy, 1);
    wait_done(20, cyc);
    chk("t1_cycles", cyc, 4);
    chk("t1_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("t1_valid_after", out_valid, 0);
    chk("t1_done_after", done, 0);
    chk("t1_done_cnt", n_done - d0, 1);
    // WALK pol=0, 10 beats, wraps past MSB
    go(2'd1, 1'b0, 10);
    wait_done(30, cyc);
    chk("t2_cycles", cyc, 11);
    chk("t2_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    // COUNT pol=1 with a 2-cycle stall on beat 1
    go(2'd2, 1'b1, 4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_word", data_out, exp_word(2'd2, 1'b1, 1));
    out_ready = 1'b1;
    wait_done(30, cyc);
    chk("t3_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    // stop with acceptance of beat index 4 of 8; concurrent start ignored
    d0 = n_done;
    go(2'd2, 1'b0, 8);
    repeat (4) @(posedge clk);
    #1;
    stop = 1'b1; start = 1'b1; mode = 2'd0; beats = 16'd2;
    @(posedge clk); #1;
    stop = 1'b0; start = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_valid", out_valid, 0);
    chk("t4_left", exp_q.size(), 3);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("t4_still_idle", busy, 0);
    chk("t4_no_done", n_done - d0, 0);
    // zero beats: done pulse only
    d0 = n_done;
    go(2'd0, 1'b1, 0);
    chk("t5_done", done, 1);
    chk("t5_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("t5_done_off", done, 0);
    chk("t5_done_cnt", n_done - d0, 1);
    // reset mid-run
    go(2'd1, 1'b1, 5);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_data", data_out, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    // mode 3
`ifdef PATTERN_SEQ_GEN_LFSR_EN
    go(2'd3, 1'b1, 127);
    chk("t6_first", data_out, 7'h7F);
    wait_done(300, cyc);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_end", data_out, 7'h7F);
`else
    go(2'd3, 1'b1, 3);
    chk("t6_first", data_out, exp_word(2'd0, 1'b1, 0));
    wait_done(20, cyc);
    chk("t6_cycles", cyc, 4);
    chk("t6_q_empty", exp_q.size(), 0);
`endif
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
